// File: rtl/cavlc_ctrl_seq.sv
// cavlc_ctrl_seq: arbitrates the barrel shifter between CAVLC decoders and sequences blocks back-to-back
module cavlc_ctrl_seq #(
  parameter int SHIFT_W = 5,
  parameter int COEFF_W = 5,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Enable,
  input  logic               BarrelShifterReady,
  input  logic [CNT_W-1:0]   NumBlocks,
  input  logic [COEFF_W-1:0] MaxNumCoeff,
  input  logic [COEFF_W-1:0] TotalCoeff,
  input  logic               CoeffTokenDecodeDone,
  input  logic [SHIFT_W-1:0] NumShift_CoeffTokenDecode,
  input  logic               ShiftEn_LevelDecode,
  input  logic [SHIFT_W-1:0] NumShift_LevelDecode,
  input  logic               LevelDecodeDone,
  input  logic               ShiftEn_ZeroDecode,
  input  logic [SHIFT_W-1:0] NumShift_ZeroDecode,
  input  logic               ZeroDecodeDone,
  output logic               ShiftEn,
  output logic [SHIFT_W-1:0] NumShift,
  output logic               BarrelShiftEn,
  output logic               CoeffTokenDecodeEnable,
  output logic               LevelDecodeEnable,
  output logic               ZeroDecodeEnable,
  output logic               BlockDone,
  output logic               RunDone,
  output logic [CNT_W-1:0]   BlockCount,
  output logic               Busy,
  output logic               Error
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WAIT_BS, CT_START, CT_DECODE, LEVEL, ZERO, CHECK, ERR} state_t;
  state_t state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, nb_q, nb_d;
  logic [COEFF_W-1:0] tc_q, tc_d;
  logic bs_en_q, bs_en_d, ct_en_q, ct_en_d, lv_en_q, lv_en_d, zr_en_q, zr_en_d;
  logic blk_done_q, blk_done_d, run_done_q, run_done_d, err_q, err_d;
  logic in_stage, wd_hit;
  assign in_stage = state_q inside {CT_DECODE, LEVEL, ZERO};
  assign wd_hit = wd_q == WD_W'(TIMEOUT - 1);
  // next state; a done in the last allowed stage cycle beats the watchdog; block count bumps on entry to CHECK
  always_comb begin
    state_d = state_q;
    nb_d = nb_q;
    cnt_d = cnt_q;
    tc_d = tc_q;
    run_done_d = 1'b0;
    case (state_q)
      IDLE: if (Enable) begin
        state_d = WAIT_BS;
        cnt_d = '0;
        nb_d = NumBlocks;
      end
      WAIT_BS: state_d = BarrelShifterReady ? CT_START : WAIT_BS;
      CT_START: state_d = CT_DECODE;
      CT_DECODE: if (CoeffTokenDecodeDone) begin
        tc_d = TotalCoeff;
        state_d = TotalCoeff == '0 ? CHECK : LEVEL;
      end else if (wd_hit) state_d = ERR;
      LEVEL: if (LevelDecodeDone) state_d = tc_q == MaxNumCoeff ? CHECK : ZERO;
      else if (wd_hit) state_d = ERR;
      ZERO: state_d = ZeroDecodeDone ? CHECK : wd_hit ? ERR : ZERO;
      CHECK: if (!Enable) state_d = IDLE;
      else if (nb_q != '0 && cnt_q == nb_q) begin
        state_d = IDLE;
        run_done_d = 1'b1;
      end else state_d = CT_START;
      ERR: state_d = Enable ? ERR : IDLE;
      default: state_d = IDLE;
    endcase
    blk_done_d = state_d == CHECK;
    if (blk_done_d && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    wd_d = (state_d != state_q || !in_stage) ? '0 : wd_q + 1'b1;
    err_d = state_d == ERR;
    bs_en_d = !(state_q == IDLE && !Enable) && state_q != ERR;
    ct_en_d = state_q inside {CT_START, CT_DECODE};
    lv_en_d = state_q == LEVEL;
    zr_en_d = state_q == ZERO;
  end
  // state, counters and registered outputs; reset overrides everything
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      wd_q <= '0;
      cnt_q <= '0;
      nb_q <= '0;
      tc_q <= '0;
      bs_en_q <= 1'b0;
      ct_en_q <= 1'b0;
      lv_en_q <= 1'b0;
      zr_en_q <= 1'b0;
      blk_done_q <= 1'b0;
      run_done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q <= wd_d;
      cnt_q <= cnt_d;
      nb_q <= nb_d;
      tc_q <= tc_d;
      bs_en_q <= bs_en_d;
      ct_en_q <= ct_en_d;
      lv_en_q <= lv_en_d;
      zr_en_q <= zr_en_d;
      blk_done_q <= blk_done_d;
      run_done_q <= run_done_d;
      err_q <= err_d;
    end
  end
  assign ShiftEn = state_q == CT_DECODE ? CoeffTokenDecodeDone :
                   state_q == LEVEL ? ShiftEn_LevelDecode :
                   state_q == ZERO ? ShiftEn_ZeroDecode : 1'b0;
  assign NumShift = state_q == CT_DECODE ? NumShift_CoeffTokenDecode :
                    state_q == LEVEL ? NumShift_LevelDecode :
                    state_q == ZERO ? NumShift_ZeroDecode : '0;
  assign BarrelShiftEn = bs_en_q;
  assign CoeffTokenDecodeEnable = ct_en_q;
  assign LevelDecodeEnable = lv_en_q;
  assign ZeroDecodeEnable = zr_en_q;
  assign BlockDone = blk_done_q;
  assign RunDone = run_done_q;
  assign BlockCount = cnt_q;
  assign Busy = state_q != IDLE;
  assign Error = err_q;
endmodule

// File: doc/cavlc_ctrl_seq.md
Name: cavlc_ctrl_seq

Overview:
- Parametrised control sequencer for the CAVLC residual-block decoder.
- Arbitrates the barrel shifter between the coeff-token, level and zero-run decoders, and decodes blocks back-to-back while Enable stays high.
- Over the previous controller it adds:
  - skipping of stages when TotalCoeff is 0 or equals MaxNumCoeff;
  - a per-run block count with a programmable stop count;
  - a per-stage watchdog with a sticky error state.

Parameters:
- SHIFT_W, 5, width of all NumShift buses.
- COEFF_W, 5, width of TotalCoeff and MaxNumCoeff.
- CNT_W, 8, width of NumBlocks and BlockCount.
- TIMEOUT, 64, cycles allowed in any decode stage before error; must be ≥2. Watchdog width is clog2(TIMEOUT+1).

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- Enable  in  1  run request from external control
- BarrelShifterReady  in  1  barrel shifter holds valid data
- NumBlocks  in  CNT_W  blocks per run; 0 = unlimited; sampled on IDLE→WAIT_BS
- MaxNumCoeff  in  COEFF_W  max coeffs for block type (16, 15, 4 or 8)
- TotalCoeff  in  COEFF_W  from coeff-token decoder, valid with CoeffTokenDecodeDone
- CoeffTokenDecodeDone  in  1  coeff-token decode complete
- NumShift_CoeffTokenDecode  in  SHIFT_W
- ShiftEn_LevelDecode  in  1
- NumShift_LevelDecode  in  SHIFT_W
- LevelDecodeDone  in  1
- ShiftEn_ZeroDecode  in  1
- NumShift_ZeroDecode  in  SHIFT_W
- ZeroDecodeDone  in  1
- ShiftEn  out  1  to barrel shifter (combinational)
- NumShift  out  SHIFT_W  to barrel shifter (combinational)
- BarrelShiftEn  out  1  barrel shifter fetch enable (registered)
- CoeffTokenDecodeEnable, LevelDecodeEnable, ZeroDecodeEnable  out  1 each  registered stage enables
- BlockDone  out  1  one-cycle pulse per completed block
- RunDone  out  1  one-cycle pulse when the run ends by count
- BlockCount  out  CNT_W  blocks completed in current run
- Busy  out  1  state ≠ IDLE
- Error  out  1  sticky watchdog error

Behaviour:
- Reset:
  - state = IDLE.
  - All outputs 0, BlockCount 0, watchdog 0.
  - Reset has priority over every other event, including mid-block.
- States: IDLE, WAIT_BS, CT_START, CT_DECODE, LEVEL, ZERO, CHECK, ERR. Unused encodings go to IDLE.
- Transitions:
  - IDLE: Enable → WAIT_BS; BlockCount ← 0; latch NumBlocks.
  - WAIT_BS: BarrelShifterReady → CT_START.
  - CT_START: → CT_DECODE unconditionally.
  - CT_DECODE, on CoeffTokenDecodeDone:
    - TotalCoeff = 0 → CHECK;
    - otherwise → LEVEL.
  - LEVEL, on LevelDecodeDone:
    - TotalCoeff_q = MaxNumCoeff → CHECK;
    - otherwise → ZERO.
    - TotalCoeff_q is TotalCoeff registered on CoeffTokenDecodeDone.
  - ZERO: ZeroDecodeDone → CHECK.
  - CHECK:
    - Enable = 0 → IDLE;
    - latched NumBlocks ≠ 0 and BlockCount = NumBlocks → IDLE with RunDone;
    - otherwise → CT_START. WAIT_BS is not revisited within a run.
  - ERR: stays in ERR until Enable = 0, then → IDLE. Error clears on leaving ERR.
- BlockDone and BlockCount:
  - BlockDone is registered, asserted the cycle after entering CHECK.
  - BlockCount increments on the same edge (saturates at all-ones).
  - The CHECK decision uses the already-incremented count: CHECK is evaluated one cycle after entry. Implement CHECK as two cycles (CHECK, then decision) or increment on entry. The team decision is increment on the transition into CHECK, so BlockCount is current when CHECK evaluates.
- RunDone: registered; asserted with the CHECK→IDLE transition taken by count.
- Shift mux (combinational):
  - CT_DECODE: ShiftEn = CoeffTokenDecodeDone, NumShift = NumShift_CoeffTokenDecode.
  - LEVEL: level decoder pair.
  - ZERO: zero decoder pair.
  - Otherwise: ShiftEn = 0, NumShift = 0.
- Registered enables (one-cycle lag behind state):
  - CoeffTokenDecodeEnable ← state ∈ {CT_START, CT_DECODE}.
  - LevelDecodeEnable ← LEVEL.
  - ZeroDecodeEnable ← ZERO.
  - BarrelShiftEn ← !(IDLE & !Enable) & state ≠ ERR.
- Watchdog:
  - Clears on every state change; counts while in CT_DECODE, LEVEL or ZERO.
  - Reaching TIMEOUT with no done → ERR, Error ← 1.
  - A done arriving in the same cycle the count hits TIMEOUT wins: normal transition, no error.
- Enable dropping mid-block does not abort; the block completes, then CHECK → IDLE.

Test Plan:
- Enable = 1, NumBlocks = 2, MaxNumCoeff = 16, TotalCoeff = 3, each done 4 cycles after its stage enable → two BlockDone pulses, BlockCount = 2, RunDone once, then IDLE, Busy = 0.
- TotalCoeff = 0 → LevelDecodeEnable and ZeroDecodeEnable never assert; BlockDone 1 cycle after CoeffTokenDecodeDone.
- MaxNumCoeff = 4, TotalCoeff = 4 → ZERO skipped; ZeroDecodeEnable stays 0; BlockCount +1.
- TIMEOUT = 8, LevelDecodeDone held 0 → Error = 1 after 8 cycles in LEVEL and ShiftEn = 0; drop Enable → IDLE with Error = 0.
- NumBlocks = 0, Enable high for 5 blocks then low during LEVEL → block completes, BlockCount = 5, no RunDone, IDLE.
- Reset asserted in ZERO → next cycle all outputs 0, state IDLE.
